// File: rtl/operand_fetch_buffer_pkg.sv
// Shared widths and request type for the operand fetch buffer.
// The attached register file must be built with the same DATA_WIDTH and SIZE.
package operand_fetch_buffer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SIZE       = 32;
    localparam int ADDR_WIDTH = $clog2(SIZE);
    localparam int TAG_WIDTH  = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;

    typedef struct packed {
        addr_t addr1;
        addr_t addr2;
        tag_t  tag;
    } fetch_req_t;

endpackage

// File: rtl/operand_fetch_buffer_if.sv
// Issue-side request, register-file read/snoop and consumer-side signals of the fetch buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface operand_fetch_buffer_if;
    import operand_fetch_buffer_pkg::*;

    logic  flush;

    logic  in_valid;
    logic  in_ready;
    addr_t in_addr1;
    addr_t in_addr2;
    tag_t  in_tag;

    logic  rf_read1_en;
    addr_t rf_read1_addr;
    data_t rf_read1_data;
    logic  rf_read2_en;
    addr_t rf_read2_addr;
    data_t rf_read2_data;

    logic  wb_en;
    addr_t wb_addr;
    data_t wb_data;

    logic  out_valid;
    logic  out_ready;
    data_t out_data1;
    data_t out_data2;
    tag_t  out_tag;

    modport slave (
        input  flush,
        input  in_valid, in_addr1, in_addr2, in_tag,
        output in_ready,
        output rf_read1_en, rf_read1_addr, rf_read2_en, rf_read2_addr,
        input  rf_read1_data, rf_read2_data,
        input  wb_en, wb_addr, wb_data,
        output out_valid, out_data1, out_data2, out_tag,
        input  out_ready
    );

    modport master (
        output flush,
        output in_valid, in_addr1, in_addr2, in_tag,
        input  in_ready,
        input  rf_read1_en, rf_read1_addr, rf_read2_en, rf_read2_addr,
        output rf_read1_data, rf_read2_data,
        output wb_en, wb_addr, wb_data,
        input  out_valid, out_data1, out_data2, out_tag,
        output out_ready
    );

endinterface

// File: rtl/operand_fetch_buffer_bypass.sv
// Writeback forwarding for one buffered operand: a snooped write to the same
// register replaces the operand's current value.
module operand_bypass
    import operand_fetch_buffer_pkg::*;
(
    input  addr_t addr_i,
    input  data_t data_i,
    input  logic  wb_en_i,
    input  addr_t wb_addr_i,
    input  data_t wb_data_i,
    output data_t data_o
);

    assign data_o = (wb_en_i && (wb_addr_i == addr_i)) ? wb_data_i : data_i;

endmodule

// File: rtl/operand_fetch_buffer.sv
// Two-stage operand fetch buffer: P waits for the 1-cycle register-file read,
// O presents operands; both stages stay coherent with snooped writebacks.
module operand_fetch_buffer
    import operand_fetch_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    operand_fetch_buffer_if.slave bus
);

    logic       p_valid_q, p_valid_d;
    logic       p_held_q,  p_held_d;
    fetch_req_t p_req_q,   p_req_d;
    data_t      p_hold1_q, p_hold1_d;
    data_t      p_hold2_q, p_hold2_d;

    logic       o_valid_q, o_valid_d;
    fetch_req_t o_req_q,   o_req_d;
    data_t      o_data1_q, o_data1_d;
    data_t      o_data2_q, o_data2_d;

    logic  o_free, p_move, p_stall, in_ready, accept;
    data_t p_src1, p_src2;
    data_t p_byp1, p_byp2, o_byp1, o_byp2;

    assign o_free   = !o_valid_q || bus.out_ready;
    assign p_move   = p_valid_q && o_free;
    assign p_stall  = p_valid_q && !p_move;
    assign in_ready = !reset && !bus.flush && (!p_valid_q || p_move);
    assign accept   = bus.in_valid && in_ready;

    // The SRAM output is only trustworthy in the cycle right after the read.
    assign p_src1 = p_held_q ? p_hold1_q : bus.rf_read1_data;
    assign p_src2 = p_held_q ? p_hold2_q : bus.rf_read2_data;

    operand_bypass u_byp_p1 (
        .addr_i(p_req_q.addr1), .data_i(p_src1),
        .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .data_o(p_byp1)
    );
    operand_bypass u_byp_p2 (
        .addr_i(p_req_q.addr2), .data_i(p_src2),
        .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .data_o(p_byp2)
    );
    operand_bypass u_byp_o1 (
        .addr_i(o_req_q.addr1), .data_i(o_data1_q),
        .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .data_o(o_byp1)
    );
    operand_bypass u_byp_o2 (
        .addr_i(o_req_q.addr2), .data_i(o_data2_q),
        .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .data_o(o_byp2)
    );

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        p_valid_d = accept || p_stall;
        o_valid_d = p_move || (o_valid_q && !bus.out_ready);
        p_held_d  = p_stall;
        if (bus.flush) begin
            p_valid_d = 1'b0;
            o_valid_d = 1'b0;
            p_held_d  = 1'b0;
        end

        p_req_d = p_req_q;
        if (accept) begin
            p_req_d.addr1 = bus.in_addr1;
            p_req_d.addr2 = bus.in_addr2;
            p_req_d.tag   = bus.in_tag;
        end

        p_hold1_d = p_stall ? p_byp1 : p_hold1_q;
        p_hold2_d = p_stall ? p_byp2 : p_hold2_q;

        o_req_d   = p_move ? p_req_q : o_req_q;
        o_data1_d = p_move ? p_byp1  : o_byp1;
        o_data2_d = p_move ? p_byp2  : o_byp2;
    end

    // NOTE: state registers use <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid_q <= 1'b0;
            p_held_q  <= 1'b0;
            o_valid_q <= 1'b0;
            o_req_q   <= '0;
            o_data1_q <= '0;
            o_data2_q <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_held_q  <= p_held_d;
            o_valid_q <= o_valid_d;
            o_req_q   <= o_req_d;
            o_data1_q <= o_data1_d;
            o_data2_q <= o_data2_d;
        end
    end

    // NOTE: P payload is only observed under p_valid/p_held, so it needs no reset.
    always_ff @(posedge clk) begin
        p_req_q   <= p_req_d;
        p_hold1_q <= p_hold1_d;
        p_hold2_q <= p_hold2_d;
    end

    assign bus.in_ready      = in_ready;
    assign bus.rf_read1_en   = accept;
    assign bus.rf_read1_addr = bus.in_addr1;
    assign bus.rf_read2_en   = accept;
    assign bus.rf_read2_addr = bus.in_addr2;

    assign bus.out_valid = o_valid_q;
    assign bus.out_data1 = o_data1_q;
    assign bus.out_data2 = o_data2_q;
    assign bus.out_tag   = o_req_q.tag;

endmodule

// File: tb/tb_operand_fetch_buffer.sv
// Bench for operand_fetch_buffer: a NEW_DATA 2R1W register file model, directed
// hazard/stall/flush/reset scenarios, then randomized traffic against a request queue.
module tb_operand_fetch_buffer;
    import operand_fetch_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_buffer_if bus ();

    operand_fetch_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file with 1-cycle reads that see a same-cycle write.
    data_t rf_mem [SIZE];
    always @(posedge clk) begin
        if (bus.rf_read1_en)
            bus.rf_read1_data <= (bus.wb_en && bus.wb_addr == bus.rf_read1_addr) ? bus.wb_data : rf_mem[bus.rf_read1_addr];
        if (bus.rf_read2_en)
            bus.rf_read2_data <= (bus.wb_en && bus.wb_addr == bus.rf_read2_addr) ? bus.wb_data : rf_mem[bus.rf_read2_addr];
        if (bus.wb_en)
            rf_mem[bus.wb_addr] <= bus.wb_data;
    end

    // Reference: accepted requests still owed to the consumer, oldest first.
    // A presented operand must always equal the register file's current content.
    typedef struct {
        fetch_req_t req;
        int         acc_cyc;
    } pend_t;
    pend_t pend_q[$];

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    logic  obs_in_ready, obs_out_valid, took;
    int    take_cyc;
    data_t took_d1, took_d2;
    tag_t  took_tag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: inputs are already driven; sample mid-cycle, then update the reference.
    task automatic step();
        logic  acc;
        pend_t e;
        #1;
        obs_in_ready  = bus.in_ready;
        obs_out_valid = bus.out_valid;
        acc  = bus.in_valid && bus.in_ready;
        took = 1'b0;
        if (reset || bus.flush)
            check("in_ready_blocked", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid) begin
            check("out_valid_has_request", 32'(pend_q.size() != 0), 32'd1);
            if (pend_q.size() != 0) begin
                e = pend_q[0];
                check("out_tag",   32'(bus.out_tag), 32'(e.req.tag));
                check("out_data1", bus.out_data1, rf_mem[e.req.addr1]);
                check("out_data2", bus.out_data2, rf_mem[e.req.addr2]);
                if (bus.out_ready) begin
                    took     = 1'b1;
                    take_cyc = cyc;
                    took_d1  = bus.out_data1;
                    took_d2  = bus.out_data2;
                    took_tag = bus.out_tag;
                end
            end
        end
        e.req.addr1 = bus.in_addr1;
        e.req.addr2 = bus.in_addr2;
        e.req.tag   = bus.in_tag;
        e.acc_cyc   = cyc;
        @(posedge clk);
        if (took) pend_q.delete(0);
        if (acc) pend_q.push_back(e);
        if (reset || bus.flush) pend_q.delete();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic request(input int a1, input int a2, input int tag);
        bus.in_valid = 1'b1;
        bus.in_addr1 = addr_t'(a1);
        bus.in_addr2 = addr_t'(a2);
        bus.in_tag   = tag_t'(tag);
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr_t'(a);
        bus.wb_data = d;
    endtask

    task automatic run_until_take(input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            bus.in_valid = 1'b0;
            bus.wb_en    = 1'b0;
            if (took) ok = 1'b1;
        end
        check("take_within_budget", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        reset = 1'b1;
        idle();
        request(0, 0, 0);
        bus.in_valid = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        @(negedge clk);

        // Preload every register while the buffer is held in reset.
        for (int i = 0; i < SIZE; i++) begin
            write_reg(i, $urandom);
            step();
        end
        idle();
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data1", bus.out_data1, 32'd0);
        check("reset_out_tag",   32'(bus.out_tag), 32'd0);
        reset = 1'b0;
        step();

        // Stream: four back-to-back requests, consumer always ready.
        base = cyc;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) request(2 * i + 1, 2 * i + 2, 8'h10 + i);
            else bus.in_valid = 1'b0;
            step();
            if (i < 4) check("stream_in_ready", 32'(obs_in_ready), 32'd1);
            if (took) begin
                check("stream_tag",     32'(took_tag), 32'(8'h10 + n));
                check("stream_latency", 32'(take_cyc - base), 32'(2 + n));
                n++;
            end
        end
        check("stream_count", 32'(n), 32'd4);

        // Stall: consumer held off for five cycles with two requests.
        idle();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            bus.out_ready = (i >= 5);
            if (i < 2) request(i + 10, i + 20, 8'h20 + i);
            else if (i < 5) request(1, 2, 8'h2F);
            else bus.in_valid = 1'b0;
            step();
            if (i < 2) check("stall_in_ready_open", 32'(obs_in_ready), 32'd1);
            else if (i < 5) check("stall_in_ready_closed", 32'(obs_in_ready), 32'd0);
            if (took) begin
                check("stall_tag", 32'(took_tag), 32'(8'h20 + n));
                n++;
            end
        end
        check("stall_count", 32'(n), 32'd2);

        // Hazard in P: write lands the cycle after the read.
        idle();
        write_reg(3, 32'h11);
        step();
        idle();
        request(3, 4, 8'h30);
        step();
        bus.in_valid = 1'b0;
        write_reg(3, 32'hAA);
        run_until_take(6);
        check("hazard_p_data1", took_d1, 32'hAA);

        // Hazard in O: two writes to an operand held at the output.
        idle();
        bus.out_ready = 1'b0;
        request(6, 5, 8'h40);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        write_reg(5, 32'h55);
        step();
        bus.wb_en = 1'b0;
        step();
        write_reg(5, 32'h66);
        step();
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        run_until_take(4);
        check("hazard_o_data2", took_d2, 32'h66);
        check("hazard_o_tag",   32'(took_tag), 32'h40);

        // Flush with both stages full; a request right after must take the normal latency.
        idle();
        bus.out_ready = 1'b0;
        request(7, 8, 8'h50);
        step();
        request(9, 10, 8'h51);
        step();
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        base = cyc;
        step();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        request(11, 12, 8'h52);
        step();
        check("flush_out_valid", 32'(obs_out_valid), 32'd0);
        run_until_take(4);
        check("flush_new_tag",     32'(took_tag), 32'h52);
        check("flush_new_latency", 32'(take_cyc - base), 32'd3);

        // Reset with both stages full; first request afterwards sees current data.
        idle();
        write_reg(9, 32'h1234);
        step();
        idle();
        bus.out_ready = 1'b0;
        request(13, 14, 8'h60);
        step();
        request(15, 16, 8'h61);
        step();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_out_data1", bus.out_data1, 32'd0);
        check("rst_mid_out_data2", bus.out_data2, 32'd0);
        check("rst_mid_out_tag",   32'(bus.out_tag), 32'd0);
        bus.out_ready = 1'b1;
        request(9, 9, 8'h62);
        step();
        bus.in_valid = 1'b0;
        run_until_take(4);
        check("rst_fresh_data1", took_d1, 32'h1234);
        check("rst_fresh_tag",   32'(took_tag), 32'h62);

        // Randomized traffic on a narrow register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_addr1  = addr_t'($urandom_range(0, 7));
            bus.in_addr2  = addr_t'($urandom_range(0, 7));
            bus.in_tag    = tag_t'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.wb_en     = ($urandom_range(0, 1) == 1);
            bus.wb_addr   = addr_t'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            step();
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) step();
        check("drain_empty", 32'(pend_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
